// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter mapping up to two requests per cycle onto a dual-port RAM, with
// per-port write turnaround, same-address conflict checks and tagged read-data return.
module ram_port_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 6,
  parameter int unsigned DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_data_a,
  output logic [DW-1:0]      ram_data_b,
  output logic               ram_we_a,
  output logic               ram_we_b,
  input  logic [DW-1:0]      ram_q_a,
  input  logic [DW-1:0]      ram_q_b
);
  localparam int unsigned IW      = $clog2(NREQ);
  localparam int unsigned LastIdx = NREQ - 1;
  localparam logic [IW:0]   NumReq = NREQ[IW:0];
  localparam logic [IW-1:0] LastId = LastIdx[IW-1:0];

  // Port index 0 is RAM port A, index 1 is port B.
  logic [IW-1:0]           rr_ptr_q;
  logic [1:0]              ta_q;
  logic [1:0]              we_q;
  logic [1:0][AW-1:0]      addr_q;
  logic [1:0][DW-1:0]      data_q;
  logic [1:0][2:0]         tv_q;
  logic [1:0][2:0][IW-1:0] tid_q;

  logic [NREQ-1:0]         gnt_c;
  logic [1:0]              sel;
  logic [1:0]              sel_we;
  logic [1:0][IW-1:0]      sel_id;
  logic [1:0][AW-1:0]      sel_addr;
  logic [1:0][DW-1:0]      sel_data;
  logic [IW-1:0]           last_id;
  logic [IW:0]             scan;
  logic [IW-1:0]           idx;
  logic                    cand_we;
  logic [AW-1:0]           cand_addr;
  logic                    clash;
  logic                    placed;

  always_comb begin
    gnt_c     = '0;
    sel       = '0;
    sel_we    = '0;
    sel_id    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    last_id   = rr_ptr_q;
    scan      = '0;
    idx       = '0;
    cand_we   = 1'b0;
    cand_addr = '0;
    clash     = 1'b0;
    placed    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + k[IW:0];
      if (scan >= NumReq) scan = scan - NumReq;
      idx       = scan[IW-1:0];
      cand_we   = req_we[idx];
      cand_addr = req_addr[idx*AW +: AW];
      clash     = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (sel[p] && (sel_addr[p] == cand_addr) && (sel_we[p] || cand_we)) clash = 1'b1;
      end
      placed = 1'b0;
      if (req[idx] && !rst && !clash) begin
        // Lowest free port that may take this access; writes avoid a turning-around port.
        for (int p = 0; p < 2; p++) begin
          if (!placed && !sel[p] && (!cand_we || !ta_q[p])) begin
            placed      = 1'b1;
            sel[p]      = 1'b1;
            sel_we[p]   = cand_we;
            sel_id[p]   = idx;
            sel_addr[p] = cand_addr;
            sel_data[p] = req_wdata[idx*DW +: DW];
            gnt_c[idx]  = 1'b1;
            last_id     = idx;
          end
        end
      end
    end
  end

  assign gnt = gnt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      ta_q     <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tv_q     <= '0;
      tid_q    <= '0;
    end else begin
      if (|gnt_c) rr_ptr_q <= (last_id == LastId) ? '0 : last_id + 1'b1;
      for (int p = 0; p < 2; p++) begin
        we_q[p]  <= sel[p] & sel_we[p];
        ta_q[p]  <= sel[p] & ~sel_we[p];
        if (sel[p]) begin
          addr_q[p] <= sel_addr[p];
          data_q[p] <= sel_data[p];
        end
        // Tag stages: RAM drive, address capture, q update; stage 2 routes q back.
        tv_q[p]  <= {tv_q[p][1:0], sel[p] & ~sel_we[p]};
        tid_q[p] <= {tid_q[p][1:0], sel_id[p]};
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int p = 0; p < 2; p++) begin
      if (tv_q[p][2]) begin
        rvalid[tid_q[p][2]]         = 1'b1;
        rdata[tid_q[p][2]*DW +: DW] = (p == 0) ? ram_q_a : ram_q_b;
      end
    end
  end

  assign ram_addr_a = addr_q[0];
  assign ram_addr_b = addr_q[1];
  assign ram_data_a = data_q[0];
  assign ram_data_b = data_q[1];
  assign ram_we_a   = we_q[0];
  assign ram_we_b   = we_q[1];

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the 64x8 true dual-port RAM (registered-address read, 2-edge read path, write-priority per port) among NREQ requesters.
- Each cycle, grants up to two requests in round-robin order and maps them onto RAM ports A and B.
- Enforces port turnaround and same-address conflict rules, and routes read data back to the issuing requester with a fixed latency.
- Sits between client engines and the RAM. Those are the RAM's only drivers.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 6, address width
- DW, 8, data width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request valid per requester
- req_we  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*AW  flat address vector; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  flat write data vector
- gnt  out  NREQ  combinational; request i is accepted at the end of this cycle
- rvalid  out  NREQ  read data valid for requester i
- rdata  out  NREQ*DW  read data; slice i is valid when rvalid[i]=1
- ram_addr_a, ram_addr_b  out  AW  registered RAM port addresses
- ram_data_a, ram_data_b  out  DW  registered RAM write data
- ram_we_a, ram_we_b  out  1  registered RAM write enables
- ram_q_a, ram_q_b  in  DW  RAM read outputs

Behaviour:
- Reset (rst=1 at an edge):
  - rr_ptr=0; all ram_* outputs=0; turnaround flags=0; read-tag pipelines cleared; rvalid=0.
  - gnt=0 while rst=1.
  - In-flight reads are dropped and never produce rvalid.
- Selection (combinational, cycle t):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... (mod NREQ); only those with req=1 are considered.
  - Assign each candidate to the lowest-lettered free port (A before B) that can accept it.
  - A read can go to any free port. A write can only go to a free port whose turnaround flag is 0.
  - Skip a candidate if its address equals an address already granted this cycle and either access is a write. Two reads to the same address are both allowed.
  - Stop when both ports are assigned or the scan ends.
  - gnt[i]=1 for each assigned candidate. At most 2 bits of gnt are set.
- Pointer: if any grant was made, rr_ptr <= (index of last granted requester + 1) mod NREQ; otherwise rr_ptr is unchanged.
- Issue (edge ending cycle t):
  - A port with a grant loads addr, wdata and we from its requester.
  - A port without a grant loads we=0 and holds its previous addr and data.
- Turnaround:
  - A port's flag is set for cycle t+1 when it issued a read in t+1 (ram_we=0 with a read grant).
  - While the flag is set, no write may be issued on that port in the next cycle. This is required because the RAM updates q only when we=0 on the edge after the address is captured.
- Read latency:
  - A read granted in cycle t drives its RAM port in t+1.
  - The RAM captures the address at the end of t+1, and q updates at the end of t+2.
  - rvalid[i]=1 with rdata slice i = that port's ram_q, combinationally, in cycle t+3, for exactly 1 cycle.
  - A 3-stage tag pipeline per port (valid + requester id) implements this routing.
- Writes: a write granted in t reaches the RAM at the end of t+1. No acknowledgement beyond gnt.
- Both ports may return data to different requesters in the same cycle. One requester can have up to 2 reads in flight per cycle; data returns in grant order.
- A requester holds req, we, addr and wdata stable until it sees gnt.
- rdata slices with rvalid=0 are don't-care; drive them to 0.

Test Plan:
1. Reset, then req[0]=1 write addr 5 data 0xA5. Next, req[1]=1 read addr 5 → gnt[0] first. Then gnt[1]; rvalid[1]=1 three cycles after gnt[1] with rdata=0xA5.
2. All 4 requesters issue reads to addrs 1,2,3,4 in the same cycle with rr_ptr=0 → gnt=0011 (port A=0, port B=1). Next cycle gnt=1100; rr_ptr returns to 0. Each rvalid arrives exactly 3 cycles after its grant.
3. req0 write addr 9 and req1 read addr 9 in the same cycle → only gnt[0]; req1 granted next cycle and reads the new data. Reads from req2 and req3 to addr 9 in the same cycle → both granted.
4. Port A reads in cycle t. In t+1, the only requests are two writes → first write goes to port B. Second write waits until t+2 on port A. rvalid for the read is unaffected.
5. Issue 2 reads, assert rst for 1 cycle before their data returns → no rvalid afterwards; all ram_we=0; rr_ptr=0.
6. req3 held continuously while req0–req2 toggle every cycle → req3 granted within 2 cycles of every request (no starvation). Confirm gnt never exceeds 2 bits.
